// File: rtl/factorial_pkg.sv
// Shared definitions for the factorial sequencing controller.
//   state_e : FSM state encoding (3-bit)
//   FACT_W  : default data width
package factorial_pkg;

  localparam int unsigned FACT_W = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT     = 3'd1,
    MUL_REQ  = 3'd2,
    MUL_WAIT = 3'd3,
    UPDATE   = 3'd4,
    DONE     = 3'd5
  } state_e;

endpackage

// File: rtl/factorial_ctrl_fsm.sv
// Sequencing FSM for factorial_ctrl: state register plus next-state decode.
// Inputs : op_start, mul_done, count_is_one, ovf_hit, op_clear (tie low when unused)
// Outputs: state_o, single-cycle datapath enables (*_c), registered
//          mul_start / busy / done decoded from the next state.
module factorial_ctrl_fsm
  import factorial_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   op_start,
  input  logic   mul_done,
  input  logic   count_is_one,
  input  logic   ovf_hit,
  input  logic   op_clear,
  output state_e state_o,
  output logic   accept_c,
  output logic   init_c,
  output logic   capture_c,
  output logic   update_c,
  output logic   abort_c,
  output logic   go_req_c,
  output logic   mul_start,
  output logic   busy,
  output logic   done
);

  state_e state_q, state_d;
  logic   mul_start_q, mul_start_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;

  // Next-state and enable decode
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    init_c    = 1'b0;
    capture_c = 1'b0;
    update_c  = 1'b0;
    abort_c   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (op_start) begin
          state_d  = INIT;
          accept_c = 1'b1;
        end
      end
      INIT: begin
        init_c  = 1'b1;
        state_d = count_is_one ? DONE : MUL_REQ;
      end
      MUL_REQ: state_d = MUL_WAIT;
      MUL_WAIT: begin
        if (mul_done) begin
          capture_c = 1'b1;
          state_d   = UPDATE;
        end
      end
      UPDATE: begin
        update_c = 1'b1;
        state_d  = (ovf_hit || count_is_one) ? DONE : MUL_REQ;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides every other transition and suppresses datapath updates
    if (op_clear && (state_q != IDLE)) begin
      state_d   = IDLE;
      abort_c   = 1'b1;
      accept_c  = 1'b0;
      init_c    = 1'b0;
      capture_c = 1'b0;
      update_c  = 1'b0;
    end
    go_req_c    = (state_d == MUL_REQ);
    mul_start_d = (state_d == MUL_REQ);
    busy_d      = (state_d == INIT) || (state_d == MUL_REQ) ||
                  (state_d == MUL_WAIT) || (state_d == UPDATE);
    done_d      = (state_d == DONE);
  end

  // State and status registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mul_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mul_start_q <= mul_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign state_o   = state_q;
  assign mul_start = mul_start_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: rtl/factorial_ctrl.sv
// Factorial sequencing controller. Computes N! by driving an external
// multi-cycle multiplier (start/done handshake), multiplying in descending
// order 1*N*(N-1)*...*2 and stopping early on overflow.
// Ports: clk, reset_n (sync, active-low), op_start, n_value, op_clear
//        (only with FACT_ABORT_EN), mul_start/mul_a/mul_b/mul_done/
//        mul_product (multiplier handshake), result, busy, done, overflow.
// Macro FACT_ABORT_EN: adds op_clear abort input.
module factorial_ctrl
  import factorial_pkg::*;
#(
  parameter int unsigned W = FACT_W
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           op_start,
`ifdef FACT_ABORT_EN
  input  logic           op_clear,
`endif
  input  logic [W-1:0]   n_value,
  output logic           mul_start,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic           mul_done,
  input  logic [2*W-1:0] mul_product,
  output logic [W-1:0]   result,
  output logic           busy,
  output logic           done,
  output logic           overflow
);

  state_e state;
  logic   clear;
  logic   accept, init, capture, update, abort, go_req;
  logic   count_is_one;

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] result_q, result_d;
  logic [W-1:0] prod_lo_q, prod_lo_d;
  logic         prod_hi_nz_q, prod_hi_nz_d;
  logic         overflow_q, overflow_d;
  logic [W-1:0] mul_a_q, mul_a_d;
  logic [W-1:0] mul_b_q, mul_b_d;

`ifdef FACT_ABORT_EN
  assign clear = op_clear;
`else
  assign clear = 1'b0;
`endif

  // INIT ends on N<=1; UPDATE ends when the decremented count reaches 1
  assign count_is_one = (state == INIT) ? (count_q <= W'(1)) : (count_q == W'(2));

  factorial_ctrl_fsm u_fsm (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_start     (op_start),
    .mul_done     (mul_done),
    .count_is_one (count_is_one),
    .ovf_hit      (prod_hi_nz_q),
    .op_clear     (clear),
    .state_o      (state),
    .accept_c     (accept),
    .init_c       (init),
    .capture_c    (capture),
    .update_c     (update),
    .abort_c      (abort),
    .go_req_c     (go_req),
    .mul_start    (mul_start),
    .busy         (busy),
    .done         (done)
  );

  // Datapath next-value logic
  always_comb begin
    count_d      = count_q;
    result_d     = result_q;
    prod_lo_d    = prod_lo_q;
    prod_hi_nz_d = prod_hi_nz_q;
    overflow_d   = overflow_q;
    if (accept) begin
      count_d = n_value;
    end else if (update && !prod_hi_nz_q) begin
      count_d = count_q - W'(1);
    end
    if (init) begin
      result_d = W'(1);
    end else if (update) begin
      result_d = prod_lo_q;
    end
    if (capture) begin
      prod_lo_d    = mul_product[W-1:0];
      prod_hi_nz_d = |mul_product[2*W-1:W];
    end
    if (accept || abort) begin
      overflow_d = 1'b0;
    end else if (update && prod_hi_nz_q) begin
      overflow_d = 1'b1;
    end
    // Operands load alongside the transition into MUL_REQ and then hold
    mul_a_d = go_req ? result_d : mul_a_q;
    mul_b_d = go_req ? count_d  : mul_b_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q      <= '0;
      result_q     <= '0;
      prod_lo_q    <= '0;
      prod_hi_nz_q <= 1'b0;
      overflow_q   <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
    end else begin
      count_q      <= count_d;
      result_q     <= result_d;
      prod_lo_q    <= prod_lo_d;
      prod_hi_nz_q <= prod_hi_nz_d;
      overflow_q   <= overflow_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
    end
  end

  assign result   = result_q;
  assign overflow = overflow_q;
  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;

endmodule

// File: tb/tb_factorial_ctrl.sv
// Self-checking bench for factorial_ctrl with a behavioural multiplier and
// a plain-arithmetic factorial reference model.
module tb_factorial_ctrl;

  localparam int unsigned TW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          op_start;
  logic          op_clear;
  logic [TW-1:0] n_value;
  logic          mul_start;
  logic [TW-1:0] mul_a, mul_b;
  logic          mul_done;
  logic [2*TW-1:0] mul_product;
  logic [TW-1:0] result;
  logic          busy, done, overflow;

  int checks = 0;
  int errors = 0;
  int mul_lat = 3;
  logic [63:0] req_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_res;
  logic        exp_ovf;

  always #5 clk = ~clk;

  factorial_ctrl #(.W(TW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .op_start    (op_start),
`ifdef FACT_ABORT_EN
    .op_clear    (op_clear),
`endif
    .n_value     (n_value),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .result      (result),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow)
  );

  // Behavioural multiplier: answers mul_lat cycles after each request
  initial begin
    int pend;
    logic [63:0] pprod;
    pend = 0;
    pprod = '0;
    mul_done = 1'b0;
    mul_product = '0;
    forever begin
      @(posedge clk);
      #1;
      mul_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mul_done = 1'b1;
          mul_product = pprod;
        end
      end
      if (mul_start === 1'b1) begin
        pend = mul_lat;
        pprod = 64'(mul_a) * 64'(mul_b);
        req_q.push_back({mul_a, mul_b});
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: N! by descending multiplication, stopping on the first overflow
  task automatic ref_fact(input int n);
    logic [63:0] full;
    logic [31:0] p;
    p = 32'd1;
    exp_ovf = 1'b0;
    exp_q.delete();
    for (int k = n; k >= 2; k--) begin
      exp_q.push_back({p, 32'(k)});
      full = 64'(p) * 64'(k);
      p = full[31:0];
      if (full[63:32] != 32'd0) begin
        exp_ovf = 1'b1;
        break;
      end
    end
    exp_res = p;
  endtask

  task automatic start_op(input int n);
    @(negedge clk);
    n_value = TW'(n);
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) chk({tag, "_timeout"}, 64'(done), 64'd1);
  endtask

  task automatic wait_mul_start(input string tag);
    int cyc;
    cyc = 0;
    while (mul_start !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (mul_start !== 1'b1) chk({tag, "_nostart"}, 64'(mul_start), 64'd1);
  endtask

  task automatic check_result(input string tag, input int n);
    ref_fact(n);
    chk({tag, "_result"}, 64'(result), 64'(exp_res));
    chk({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_npulse"}, 64'(req_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < req_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_pair%0d", tag, i), req_q[i], exp_q[i]);
  endtask

  task automatic run_op(input string tag, input int n, input int lat);
    mul_lat = lat;
    req_q.delete();
    start_op(n);
    wait_done(tag);
    check_result(tag, n);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_result"}, 64'(result), 64'd0);
    chk({tag, "_mul_a"}, 64'(mul_a), 64'd0);
    chk({tag, "_mul_b"}, 64'(mul_b), 64'd0);
    chk({tag, "_mul_start"}, 64'(mul_start), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    int n, sz;
    reset_n = 1'b0;
    op_start = 1'b0;
    op_clear = 1'b0;
    n_value = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset_n = 1'b1;

    run_op("n5", 5, 3);

    // N<=1: no multiplies, done two cycles after op_start
    for (int k = 0; k <= 1; k++) begin
      req_q.delete();
      start_op(k);
      chk($sformatf("n%0d_done_early", k), 64'(done), 64'd0);
      chk($sformatf("n%0d_busy_init", k), 64'(busy), 64'd1);
      @(negedge clk);
      check_result($sformatf("n%0d", k), k);
    end

    run_op("n13", 13, 2);
    run_op("n12", 12, 5);

    // op_start during MUL_WAIT is ignored
    mul_lat = 4;
    req_q.delete();
    start_op(5);
    wait_mul_start("ign");
    @(negedge clk);
    n_value = TW'(3);
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    wait_done("ign");
    check_result("ign", 5);
    run_op("redo4", 4, 1);

    for (int t = 0; t < 10; t++) begin
      n = int'($urandom_range(0, 20));
      run_op($sformatf("rnd%0d_n%0d", t, n), n, int'($urandom_range(1, 6)));
    end

    // Reset during MUL_WAIT; the pending mul_done must be ignored
    mul_lat = 3;
    req_q.delete();
    start_op(5);
    wait_mul_start("rst");
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    sz = req_q.size();
    repeat (10) @(negedge clk);
    check_idle("rst");
    chk("rst_no_more_start", 64'(req_q.size()), 64'(sz));

`ifdef FACT_ABORT_EN
    // Abort during MUL_WAIT
    mul_lat = 4;
    run_op("pre_abort", 6, 2);
    mul_lat = 4;
    req_q.delete();
    start_op(5);
    wait_mul_start("abort");
    @(negedge clk);
    op_clear = 1'b1;
    @(negedge clk);
    op_clear = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_mul_start", 64'(mul_start), 64'd0);
    chk("abort_ovf", 64'(overflow), 64'd0);
    chk("abort_result_kept", 64'(result), 64'd1);
    sz = req_q.size();
    repeat (10) @(negedge clk);
    chk("abort_idle_busy", 64'(busy), 64'd0);
    chk("abort_idle_done", 64'(done), 64'd0);
    chk("abort_no_more_start", 64'(req_q.size()), 64'(sz));
    run_op("post_abort", 7, 3);
`else
    run_op("noabort", 5, 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
